mem_port_arbiter: RTL and testbench

Shares one single-ported unified instruction/data memory between the fetch stage (I side) and the memory stage (D side) of the five-stage RISC-V pipeline. Each pipeline step, it serves every outstanding request in turn, D before I, and holds StallMem high until all of them have completed. StallMem is ORed into the hazard unit's StallF/StallD and freezes the E/M/W registers, so the pipeline advances only when both accesses for the current step are done.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_port_arbiter: shares one memory port between fetch (I) and M stage (D)  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            IReq,
  input  logic [AW-1:0]   IAddr,
  output logic [DW-1:0]   IRData,
  input  logic            DReq,
  input  logic            DWe,
  input  logic [AW-1:0]   DAddr,
  input  logic [DW-1:0]   DWData,
  input  logic [DW/8-1:0] DBe,
  output logic [DW-1:0]   DRData,
  output logic            StallMem,
  output logic            MemReq,
  output logic            MemWe,
  output logic [AW-1:0]   MemAddr,
  output logic [DW-1:0]   MemWData,
  output logic [DW/8-1:0] MemBe,
  input  logic            MemAck,
  input  logic [DW-1:0]   MemRData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_idone;
  logic   r_ddone;
  logic   w_pend_d;
  logic   w_pend_i;
  logic   w_step_end;
  logic   w_load_d;
  logic   w_load_i;
  logic   w_set_d;
  logic   w_set_i;
  logic   w_cap_d;
  logic   w_cap_i;

  assign w_pend_d   = DReq & ~r_ddone;
  assign w_pend_i   = IReq & ~r_idone;
  assign StallMem   = w_pend_d | w_pend_i;
  // With nothing pending the step is over; IDLE then has nothing to arbitrate.
  assign w_step_end = ~StallMem;

  always_comb begin
    w_state_nxt = r_state;
    w_load_d    = 1'b0;
    w_load_i    = 1'b0;
    w_set_d     = 1'b0;
    w_set_i     = 1'b0;
    w_cap_d     = 1'b0;
    w_cap_i     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pend_d) begin
          w_load_d    = 1'b1;
          w_state_nxt = D_BUSY;
        end else if (w_pend_i) begin
          w_load_i    = 1'b1;
          w_state_nxt = I_BUSY;
        end
      end
      D_BUSY: begin
        if (MemAck) begin
          w_set_d = 1'b1;
          w_cap_d = ~MemWe;
          // Chain straight into the fetch so no idle cycle separates the two.
          if (w_pend_i) begin
            w_load_i    = 1'b1;
            w_state_nxt = I_BUSY;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      I_BUSY: begin
        if (MemAck) begin
          w_set_i     = 1'b1;
          w_cap_i     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idone <= 1'b0;
      r_ddone <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_set_d)         r_ddone <= 1'b1;
      else if (w_step_end) r_ddone <= 1'b0;
      if (w_set_i)         r_idone <= 1'b1;
      else if (w_step_end) r_idone <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      MemBe    <= '0;
    end else begin
      MemReq <= (w_state_nxt != IDLE);
      if (w_load_d) begin
        MemWe    <= DWe;
        MemAddr  <= DAddr;
        MemWData <= DWData;
        MemBe    <= DWe ? DBe : '1;
      end else if (w_load_i) begin
        MemWe   <= 1'b0;
        MemAddr <= IAddr;
        MemBe   <= '1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      IRData <= '0;
      DRData <= '0;
    end else begin
      if (w_cap_i) IRData <= MemRData;
      if (w_cap_d) DRData <= MemRData;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed bench with a memory model and txn scoreboard  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IReq;
  logic [31:0] IAddr;
  logic [31:0] IRData;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic [3:0]  DBe;
  logic [31:0] DRData;
  logic        StallMem;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBe;
  logic        MemAck = 1'b0;
  logic [31:0] MemRData = 32'h0;

  int   n_pass   = 0;
  int   n_total  = 0;
  int   mem_wait = 0;
  int   wait_cnt = 0;
  bit   spur     = 1'b0;
  int   cyc;
  txn_t sb[$];

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .IReq(IReq), .IAddr(IAddr), .IRData(IRData),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DBe(DBe), .DRData(DRData),
    .StallMem(StallMem),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemBe(MemBe),
    .MemAck(MemAck), .MemRData(MemRData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Memory model: every MemReq cycle is compared against the scoreboard head;
  // the ack comes after mem_wait wait cycles and pops the entry.
  always @(posedge clk) begin
    #1;
    if (MemReq === 1'b1) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        check("mem_we", 32'(MemWe), 32'(sb[0].we));
        check("mem_addr", MemAddr, sb[0].addr);
        check("mem_be", 32'(MemBe), 32'(sb[0].be));
        if (sb[0].we) check("mem_wdata", MemWData, sb[0].wdata);
        if (wait_cnt >= mem_wait) begin
          MemAck   = 1'b1;
          MemRData = sb[0].rdata;
          void'(sb.pop_front());
          wait_cnt = 0;
        end else begin
          MemAck   = 1'b0;
          MemRData = 32'h0;
          wait_cnt++;
        end
      end else begin
        MemAck = 1'b0;
      end
    end else begin
      wait_cnt = 0;
      MemAck   = spur;
      MemRData = spur ? 32'hFFFF_FFFF : 32'h0;
    end
  end

  // Counts stalled cycles until the step-end cycle (sampled on falling edges).
  task automatic run_step(output int cnt);
    bit done;
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (StallMem === 1'b0) done = 1'b1;
      else cnt++;
    end
    if (!done) check("step_end_reached", 32'(StallMem), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    IReq = 1'b0; IAddr = 32'h0;
    DReq = 1'b0; DWe = 1'b0; DAddr = 32'h0; DWData = 32'h0; DBe = 4'h0;

    repeat (2) @(negedge clk);
    check("rst_memreq", 32'(MemReq), 32'd0);
    check("rst_memaddr", MemAddr, 32'h0);
    check("rst_membe", 32'(MemBe), 32'h0);
    check("rst_irdata", IRData, 32'h0);
    check("rst_drdata", DRData, 32'h0);
    check("rst_stall", 32'(StallMem), 32'd0);
    reset_n = 1'b1;

    // Reset while a load is waiting on memory, then reissue.
    @(posedge clk); #2;
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h100; mem_wait = 10;
    sb.push_back('{we:1'b0, addr:32'h100, wdata:32'h0, be:4'hF, rdata:32'h1111_1111});
    @(negedge clk);
    check("arb_stall", 32'(StallMem), 32'd1);
    check("arb_memreq", 32'(MemReq), 32'd0);
    @(negedge clk);
    check("dbusy_memreq", 32'(MemReq), 32'd1);
    check("dbusy_addr", MemAddr, 32'h100);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_memreq", 32'(MemReq), 32'd0);
    check("midrst_drdata", DRData, 32'h0);
    check("midrst_stall", 32'(StallMem), 32'd1);
    @(negedge clk);
    mem_wait = 0;
    reset_n  = 1'b1;
    run_step(cyc);
    check("reissue_drdata", DRData, 32'h1111_1111);

    // Fetch only, zero-wait.
    @(posedge clk); #2;
    DReq = 1'b0; IReq = 1'b1; IAddr = 32'h40;
    sb.push_back('{we:1'b0, addr:32'h40, wdata:32'h0, be:4'hF, rdata:32'h0050_0093});
    run_step(cyc);
    check("fetch_stall_cycles", 32'(cyc), 32'd2);
    check("fetch_irdata", IRData, 32'h0050_0093);
    check("fetch_drdata_held", DRData, 32'h1111_1111);

    // Load plus fetch in one step.
    @(posedge clk); #2;
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h200; IAddr = 32'h44;
    sb.push_back('{we:1'b0, addr:32'h200, wdata:32'h0, be:4'hF, rdata:32'hA5A5_0001});
    sb.push_back('{we:1'b0, addr:32'h44,  wdata:32'h0, be:4'hF, rdata:32'h00A0_0113});
    run_step(cyc);
    check("ld_fetch_stall_cycles", 32'(cyc), 32'd3);
    check("ld_fetch_drdata", DRData, 32'hA5A5_0001);
    check("ld_fetch_irdata", IRData, 32'h00A0_0113);

    // Store with three wait states.
    @(posedge clk); #2;
    IReq = 1'b0; DReq = 1'b1; DWe = 1'b1; DAddr = 32'h300; DWData = 32'hDEAD_BEEF; DBe = 4'b0011;
    mem_wait = 3;
    sb.push_back('{we:1'b1, addr:32'h300, wdata:32'hDEAD_BEEF, be:4'b0011, rdata:32'hBAD0_BAD0});
    run_step(cyc);
    check("st_stall_cycles", 32'(cyc), 32'd5);
    check("st_drdata_held", DRData, 32'hA5A5_0001);
    mem_wait = 0;

    // Spurious acks with no requests.
    @(posedge clk); #2;
    DReq = 1'b0; DWe = 1'b0; spur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("spur_stall", 32'(StallMem), 32'd0);
      check("spur_memreq", 32'(MemReq), 32'd0);
      check("spur_irdata", IRData, 32'h00A0_0113);
      check("spur_drdata", DRData, 32'hA5A5_0001);
    end
    spur = 1'b0;

    // Back-to-back fetch steps with IReq held high.
    @(posedge clk); #2;
    IReq = 1'b1; IAddr = 32'h48;
    sb.push_back('{we:1'b0, addr:32'h48, wdata:32'h0, be:4'hF, rdata:32'h0000_0001});
    run_step(cyc);
    check("b2b1_stall_cycles", 32'(cyc), 32'd2);
    check("b2b1_irdata", IRData, 32'h0000_0001);
    check("b2b_stepend_memreq", 32'(MemReq), 32'd0);
    @(posedge clk); #2;
    IAddr = 32'h4C;
    sb.push_back('{we:1'b0, addr:32'h4C, wdata:32'h0, be:4'hF, rdata:32'h0000_0002});
    @(negedge clk);
    check("b2b2_arb_stall", 32'(StallMem), 32'd1);
    check("b2b2_arb_memreq", 32'(MemReq), 32'd0);
    @(negedge clk);
    check("b2b2_memreq", 32'(MemReq), 32'd1);
    check("b2b2_addr", MemAddr, 32'h4C);
    run_step(cyc);
    check("b2b2_irdata", IRData, 32'h0000_0002);

    @(posedge clk); #2;
    IReq = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
